// File: rtl/rdout_seq.sv
// Readout sequencer: free-running 16-phase frame counter plus an event FSM that
// streams the SCA sample addresses of one or two blocks and pops the trigger FIFO.
module rdout_seq #(
    parameter int TMR   = 0,
    parameter int NSAMP = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        TEMPTY,
    input  logic [3:0]  BLKOUT,
    input  logic        SCND_BLK,
    input  logic        DBUSY,
    output logic [3:0]  STATE,
    output logic        PBEND,
    output logic        RD_ACT,
    output logic [3:0]  RD_BLK,
    output logic [3:0]  SMP_ADR,
    output logic        DRDY,
    output logic        LAST,
    output logic        TRGDONE,
    output logic        POPL1AN,
    output logic [11:0] EVT_CNT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SAMP = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam logic [3:0] SMP_END = 4'(NSAMP - 1);
    localparam int         NCP     = (TMR != 0) ? 3 : 1;
    // Protected state packed as {fsm[1:0], frame[3:0], armed}; reset leaves armed set.
    localparam logic [6:0] TMR_RST = 7'b00_0000_1;

    function automatic logic [6:0] maj3(input logic [6:0] a, input logic [6:0] b,
                                        input logic [6:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [6:0]  tmr_q [NCP];
    logic [6:0]  tmr_d;
    logic [6:0]  tmr_v;

    fsm_t        fsm_v;
    fsm_t        fsm_d;
    logic [3:0]  frm_v;
    logic [3:0]  frm_d;
    logic        armed_v;
    logic        armed_d;

    logic        start_s;
    logic        xfer_s;
    logic        end_s;

    logic [3:0]  rd_blk_q,  rd_blk_d;
    logic [3:0]  smp_adr_q, smp_adr_d;
    logic        scnd_q,    scnd_d;
    logic        blk_idx_q, blk_idx_d;
    logic        drdy_q,    drdy_d;
    logic        last_q,    last_d;
    logic        rd_act_q,  rd_act_d;
    logic        trgdone_q, trgdone_d;
    logic        popl1an_q, popl1an_d;
    logic        pbend_q,   pbend_d;
    logic [11:0] evt_cnt_q, evt_cnt_d;

    generate
        if (TMR != 0) begin : g_vote
            assign tmr_v = maj3(tmr_q[0], tmr_q[1], tmr_q[2]);
        end else begin : g_single
            assign tmr_v = tmr_q[0];
        end
    endgenerate

    assign fsm_v   = fsm_t'(tmr_v[6:5]);
    assign frm_v   = tmr_v[4:1];
    assign armed_v = tmr_v[0];
    assign tmr_d   = {fsm_d, frm_d, armed_d};

    assign start_s = (fsm_v == IDLE) && (frm_v == 4'd3) && !TEMPTY && armed_v;
    assign xfer_s  = (fsm_v == SAMP) && !DBUSY;
    assign end_s   = (smp_adr_q == SMP_END) && (blk_idx_q || !scnd_q);

    // State register: protected copies of FSM, frame counter and armed flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NCP; i++) begin
                tmr_q[i] <= TMR_RST;
            end
        end else begin
            for (int i = 0; i < NCP; i++) begin
                tmr_q[i] <= tmr_d;
            end
        end
    end

    // Next-state logic for the event FSM.
    always_comb begin
        fsm_d = fsm_v;
        case (fsm_v)
            IDLE: begin
                if (start_s) fsm_d = SAMP;
                else         fsm_d = IDLE;
            end
            SAMP: begin
                if (xfer_s && end_s) fsm_d = DONE;
                else                 fsm_d = SAMP;
            end
            DONE:    fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // Frame counter and armed flag; a pop in phase 1 must not re-arm in the same cycle.
    always_comb begin
        frm_d = frm_v + 4'd1;
        if (fsm_v == DONE) begin
            armed_d = 1'b0;
        end else if (frm_v == 4'd1) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_v;
        end
    end

    // Output and datapath logic, computed from the next FSM state so outputs stay registered.
    always_comb begin
        rd_blk_d  = rd_blk_q;
        smp_adr_d = smp_adr_q;
        scnd_d    = scnd_q;
        blk_idx_d = blk_idx_q;
        if (start_s) begin
            rd_blk_d  = BLKOUT;
            scnd_d    = SCND_BLK;
            smp_adr_d = 4'd0;
            blk_idx_d = 1'b0;
        end else if (xfer_s && !end_s) begin
            if (smp_adr_q != SMP_END) begin
                smp_adr_d = smp_adr_q + 4'd1;
            end else begin
                rd_blk_d  = rd_blk_q + 4'd1;
                smp_adr_d = 4'd0;
                blk_idx_d = 1'b1;
            end
        end else begin
            rd_blk_d  = rd_blk_q;
            smp_adr_d = smp_adr_q;
        end
        drdy_d    = (fsm_d == SAMP);
        rd_act_d  = (fsm_d != IDLE);
        trgdone_d = (fsm_d == DONE);
        popl1an_d = (fsm_d == DONE);
        last_d    = drdy_d && (smp_adr_d == SMP_END) && (blk_idx_d || !scnd_d);
        pbend_d   = (frm_d == 4'd15);
        if (fsm_d == DONE) begin
            evt_cnt_d = evt_cnt_q + 12'd1;
        end else begin
            evt_cnt_d = evt_cnt_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_blk_q  <= 4'd0;
            smp_adr_q <= 4'd0;
            scnd_q    <= 1'b0;
            blk_idx_q <= 1'b0;
            drdy_q    <= 1'b0;
            last_q    <= 1'b0;
            rd_act_q  <= 1'b0;
            trgdone_q <= 1'b0;
            popl1an_q <= 1'b0;
            pbend_q   <= 1'b0;
            evt_cnt_q <= 12'd0;
        end else begin
            rd_blk_q  <= rd_blk_d;
            smp_adr_q <= smp_adr_d;
            scnd_q    <= scnd_d;
            blk_idx_q <= blk_idx_d;
            drdy_q    <= drdy_d;
            last_q    <= last_d;
            rd_act_q  <= rd_act_d;
            trgdone_q <= trgdone_d;
            popl1an_q <= popl1an_d;
            pbend_q   <= pbend_d;
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign STATE   = frm_v;
    assign PBEND   = pbend_q;
    assign RD_ACT  = rd_act_q;
    assign RD_BLK  = rd_blk_q;
    assign SMP_ADR = smp_adr_q;
    assign DRDY    = drdy_q;
    assign LAST    = last_q;
    assign TRGDONE = trgdone_q;
    assign POPL1AN = popl1an_q;
    assign EVT_CNT = evt_cnt_q;

endmodule

// File: doc/rdout_seq.md
# rdout_seq

Readout sequencer for the trigger/block FIFO in the readout controller. Generates the free-running 16-phase frame counter (STATE, PBEND) that the controller decodes, waits for a pending trigger entry, and streams the SCA sample addresses of one or two pretrigger blocks to the downstream serializer under a ready/busy handshake. When the event is finished it issues the FIFO pop strobes (TRGDONE, POPL1AN).

## Interface
Parameters:
- TMR, 0, 1 = triplicate the FSM state, the frame counter and the armed flag with majority voting; no functional difference.
- NSAMP, 8, samples per block; legal range 1..16.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- TEMPTY  in  1  trigger FIFO empty
- BLKOUT  in  4  FIFO head: first block number (valid when TEMPTY=0)
- SCND_BLK  in  1  FIFO head: a second consecutive block is also to be read
- DBUSY  in  1  downstream busy; a sample transfers on a cycle with DRDY=1 and DBUSY=0
- STATE  out  4  frame phase 0..15
- PBEND  out  1  block-end strobe, 1 when STATE==15
- RD_ACT  out  1  event readout in progress (SAMP or DONE)
- RD_BLK  out  4  block currently being read
- SMP_ADR  out  4  sample address within RD_BLK
- DRDY  out  1  sample address valid
- LAST  out  1  current sample is the final one of the event
- TRGDONE  out  1  one-cycle trigger FIFO pop
- POPL1AN  out  1  one-cycle L1A-number FIFO pop, coincident with TRGDONE
- EVT_CNT  out  12  completed-event counter

## Operation
- Frame counter: STATE increments every CLK and wraps 15->0. It is independent of the FSM. PBEND is a registered decode, high exactly while STATE==15.
- Armed flag: set to 1 by reset. Cleared in the DONE cycle. Set again in any cycle with STATE==1. This guarantees that the FIFO empty flag has been refreshed (it is updated in phase 1) before the next start.
- FSM states: IDLE, SAMP, DONE.
  - IDLE -> SAMP when STATE==3 && TEMPTY==0 && armed. In that cycle: capture BLKOUT into RD_BLK and SCND_BLK into scnd_q, clear SMP_ADR to 0, and clear the block-index bit.
  - In SAMP, DRDY=1. On each transfer (DBUSY=0):
    - SMP_ADR<NSAMP-1: SMP_ADR+1.
    - SMP_ADR==NSAMP-1, first block and scnd_q=1: RD_BLK <= RD_BLK+1 mod 16, SMP_ADR <= 0, set block-index bit. There is no gap cycle.
    - Otherwise: go to DONE.
  - While DBUSY=1, all outputs hold.
  - DONE lasts one cycle: TRGDONE=1, POPL1AN=1, EVT_CNT+1 (wraps 4095->0, no saturation), then IDLE. DRDY=0 in DONE.
- LAST = DRDY && SMP_ADR==NSAMP-1 && (block-index bit set || scnd_q==0).
- RD_ACT = 1 in SAMP and DONE.
- DBUSY is ignored outside SAMP. TEMPTY is sampled only in IDLE at STATE==3.
- Reset mid-event: everything returns to reset values immediately. No pop is issued, so the FIFO entry is re-read after reset.

## Timing
- Reset values: STATE=0, PBEND=0, RD_ACT=0, RD_BLK=0, SMP_ADR=0, DRDY=0, LAST=0, TRGDONE=0, POPL1AN=0, EVT_CNT=0, FSM=IDLE, armed=1.
- All outputs are registered.
- Capture occurs in cycle t (STATE==3). The first DRDY is at t+1 with SMP_ADR=0.
- Single-block event without backpressure: DRDY during t+1..t+NSAMP, TRGDONE at t+NSAMP+1.
- Two-block event: DRDY during t+1..t+2*NSAMP, TRGDONE at t+2*NSAMP+1.
- Each DBUSY cycle during SAMP delays every later event by one cycle.
- Earliest next start is the next STATE==3 after a subsequent STATE==1. Back-to-back events therefore start 16 or 32 cycles apart, depending on length.
- RD_BLK wrap: BLKOUT=15 with SCND_BLK=1 reads block 15, then block 0.

## Test plan
- Reset release, TEMPTY=1 for 40 cycles: STATE counts 0..15..0; PBEND high only at STATE==15; DRDY and TRGDONE stay 0.
- NSAMP=8, BLKOUT=5, SCND_BLK=0, TEMPTY falls at STATE=0: capture at STATE=3; DRDY for 8 cycles with SMP_ADR 0..7 and RD_BLK=5; LAST on SMP_ADR 7; TRGDONE and POPL1AN at STATE=12; EVT_CNT=1.
- BLKOUT=15, SCND_BLK=1: 16 DRDY cycles, RD_BLK 15 for addresses 0..7 then 0 for 0..7; LAST only on the 16th; a single TRGDONE pulse.
- DBUSY high for 3 cycles at SMP_ADR=2: SMP_ADR holds at 2 with DRDY=1; TRGDONE delayed by exactly 3 cycles.
- TEMPTY held 0 for two queued events, NSAMP=8, single block: second capture at STATE=3 of the next frame (16 cycles after the first); exactly two TRGDONE pulses; EVT_CNT=2.
- RST asserted at SMP_ADR=4, released: no TRGDONE; all outputs at reset values; event restarts at the next STATE==3 with SMP_ADR=0.
